// File: rtl/shared_reg_write_arbiter.sv
// rtl/shared_reg_write_arbiter.sv - round-robin write arbiter owning one shared holding register
// Each committed write is followed by a settle window; clears are deferred to the next idle cycle.
module shared_reg_write_arbiter #(
    parameter int                NREQ       = 4,
    parameter int                WIDTH      = 8,
    parameter int                SETTLE_CYC = 2,
    parameter logic [WIDTH-1:0]  CLR_VAL    = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic                    clr,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        q,
    output logic                    busy,
    output logic [15:0]             wr_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   sel_nxt;
    logic [CW-1:0]   cnt;
    logic            clr_pend;
    logic            found;

    // First active requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        sel_nxt = ptr;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                sel_nxt = PW'((int'(ptr) + k) % NREQ);
                found   = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            q        <= CLR_VAL;
            gnt      <= '0;
            ack      <= '0;
            wr_count <= '0;
            clr_pend <= 1'b0;
            ptr      <= '0;
            sel      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr || clr_pend) begin
                        q        <= CLR_VAL;
                        clr_pend <= 1'b0;
                        cnt      <= '0;
                        state    <= SETTLE;
                    end else if (|req) begin
                        sel   <= sel_nxt;
                        gnt   <= NREQ'(1) << sel_nxt;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    gnt <= '0;
                    if (clr) clr_pend <= 1'b1;
                    // A requester that let go before commit forfeits its turn without moving ptr.
                    if (req[sel]) begin
                        q        <= req_data[sel*WIDTH +: WIDTH];
                        ack      <= NREQ'(1) << sel;
                        wr_count <= wr_count + 16'd1;
                        ptr      <= PW'((int'(sel) + 1) % NREQ);
                        cnt      <= '0;
                        state    <= SETTLE;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETTLE: begin
                    ack <= '0;
                    if (clr) clr_pend <= 1'b1;
                    if (cnt == CW'(SETTLE_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_write_arbiter.sv
// tb/tb_shared_reg_write_arbiter.sv - directed self-checking bench for shared_reg_write_arbiter
module tb_shared_reg_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        clr;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        busy;
    logic [15:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    shared_reg_write_arbiter #(
        .NREQ(4), .WIDTH(8), .SETTLE_CYC(2), .CLR_VAL(8'h00)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data), .clr(clr),
        .gnt(gnt), .ack(ack), .q(q), .busy(busy), .wr_count(wr_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 12; i++) begin
            if (gnt != 4'b0) break;
            tick();
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 12; i++) begin
            if (!busy) break;
            tick();
        end
        check("wait_idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0;
        clr   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] rr_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        req      = 4'b0;
        req_data = 32'h0;
        clr      = 1'b0;
        do_reset();
        check("rst_q", {24'b0, q}, 32'h00);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_wr_count", {16'b0, wr_count}, 32'd0);

        // single write, SETTLE_CYC=2
        req = 4'b0001; req_data[7:0] = 8'hA5;
        tick();
        check("single_gnt", {28'b0, gnt}, 32'b0001);
        check("single_busy", {31'b0, busy}, 32'd1);
        tick();
        check("single_q", {24'b0, q}, 32'hA5);
        check("single_ack", {28'b0, ack}, 32'b0001);
        check("single_gnt_off", {28'b0, gnt}, 32'd0);
        check("single_cnt", {16'b0, wr_count}, 32'd1);
        req = 4'b0;
        tick();
        check("single_ack_pulse", {28'b0, ack}, 32'd0);
        check("single_busy_t3", {31'b0, busy}, 32'd1);
        tick();
        check("single_busy_t4", {31'b0, busy}, 32'd0);

        // reset asserted mid-SETTLE
        req = 4'b0010; req_data[15:8] = 8'h3C;
        tick();
        tick();
        check("pre_rst_q", {24'b0, q}, 32'h3C);
        do_reset();
        check("midrst_q", {24'b0, q}, 32'h00);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_gnt", {28'b0, gnt}, 32'd0);
        check("midrst_ack", {28'b0, ack}, 32'd0);
        check("midrst_cnt", {16'b0, wr_count}, 32'd0);

        // round robin, each requester dropped after its ack, then req0 again
        req = 4'b1111;
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = rr_data[i];
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                req_data[7:0] = rr_data[4];
                req = 4'b0001;
            end
            wait_gnt();
            check($sformatf("rr_gnt%0d", i), {28'b0, gnt}, 32'(4'b0001 << order[i]));
            tick();
            check($sformatf("rr_ack%0d", i), {28'b0, ack}, 32'(4'b0001 << order[i]));
            check($sformatf("rr_q%0d", i), {24'b0, q}, {24'b0, rr_data[i]});
            req[order[i]] = 1'b0;
        end
        check("rr_wr_count", {16'b0, wr_count}, 32'd5);
        wait_idle();

        // ptr is now 1: with req0 and req3 both held, req3 wins
        req = 4'b1001; req_data[7:0] = 8'h0A; req_data[31:24] = 8'hD3;
        wait_gnt();
        check("rr_ptr_gnt", {28'b0, gnt}, 32'b1000);
        tick();
        check("rr_ptr_q", {24'b0, q}, 32'hD3);
        req = 4'b0001;
        wait_gnt();
        check("rr_ptr_gnt0", {28'b0, gnt}, 32'b0001);
        tick();
        req = 4'b0;
        wait_idle();

        // abort: req0 dropped during GRANT
        do_reset();
        req = 4'b0001; req_data[7:0] = 8'h77;
        tick();
        check("abort_gnt", {28'b0, gnt}, 32'b0001);
        req = 4'b0;
        tick();
        check("abort_ack", {28'b0, ack}, 32'd0);
        check("abort_q", {24'b0, q}, 32'h00);
        check("abort_cnt", {16'b0, wr_count}, 32'd0);
        check("abort_idle", {31'b0, busy}, 32'd0);
        req = 4'b0011; req_data[7:0] = 8'h66; req_data[15:8] = 8'h99;
        tick();
        check("abort_ptr_gnt", {28'b0, gnt}, 32'b0001);
        tick();
        check("abort_next_q", {24'b0, q}, 32'h66);
        req = 4'b0;
        wait_idle();

        // clear during SETTLE wins over pending req1
        req = 4'b0001; req_data[7:0] = 8'h5A;
        wait_gnt();
        tick();
        check("clr_pre_q", {24'b0, q}, 32'h5A);
        req = 4'b0010; req_data[15:8] = 8'hC3; clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        check("clr_idle", {31'b0, busy}, 32'd0);
        tick();
        check("clr_q", {24'b0, q}, 32'h00);
        check("clr_no_ack", {28'b0, ack}, 32'd0);
        check("clr_no_gnt", {28'b0, gnt}, 32'd0);
        check("clr_cnt", {16'b0, wr_count}, 32'd2);
        tick();
        tick();
        tick();
        check("clr_then_gnt", {28'b0, gnt}, 32'b0010);
        tick();
        check("clr_then_q", {24'b0, q}, 32'hC3);
        check("clr_then_ack", {28'b0, ack}, 32'b0010);
        check("clr_then_cnt", {16'b0, wr_count}, 32'd3);
        req = 4'b0;
        wait_idle();

        // wr_count wrap
        force dut.wr_count = 16'hFFFF;
        tick();
        release dut.wr_count;
        req = 4'b0100; req_data[23:16] = 8'hE7;
        wait_gnt();
        check("wrap_gnt", {28'b0, gnt}, 32'b0100);
        tick();
        check("wrap_q", {24'b0, q}, 32'hE7);
        check("wrap_cnt", {16'b0, wr_count}, 32'h0000);
        req = 4'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
